// File: rtl/trigger_wheel_pkg.sv
// trigger_wheel_pkg: shared FSM state type and default wheel geometry for trigger_wheel_gen.
package trigger_wheel_pkg;
   typedef enum logic [1:0] {IDLE, HIGH, LOW, GAP} state_t;
   localparam int TEETH_DEF      = 60;
   localparam int MISSING_DEF    = 2;
   localparam int MIN_PERIOD_DEF = 256;
endpackage

// File: rtl/trigger_wheel_gen_phase_timer.sv
// phase_timer: loadable down-counter; o_done is high while the count is zero.
//   clk     - clock, rising edge
//   rst     - asynchronous active-low reset, clears the count
//   i_load  - load i_val this cycle (takes priority over counting)
//   i_val   - phase length minus one
//   o_done  - count has reached zero
module phase_timer #(
   parameter int W = 25
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_val,
   output logic         o_done
);
   logic [W-1:0] r_cnt;
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         r_cnt <= '0;
      else if (i_load)
         r_cnt <= i_val;
      else if (r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   assign o_done = (r_cnt == '0);
endmodule

// File: rtl/trigger_wheel_gen.sv
// trigger_wheel_gen: crank/cam trigger wheel generator (TEETH-MISSING style wheel).
//   clk, rst        - clock (rising edge) and asynchronous active-low reset
//   ena             - run enable; dropping it finishes the current LOW or GAP then idles
//   period          - full tooth period in clk cycles, clamped to MIN_PERIOD
//   cam_tooth       - tooth index carrying the cam pulse (even revolutions only)
//   cap             - crank tooth signal, falling edge is the tooth event
//   cam             - cam signal, once per two revolutions
//   tooth_idx, rev  - current tooth index and revolution parity
//   sync            - one-cycle strobe on the tooth-0 falling edge
//   running         - FSM is not IDLE
module trigger_wheel_gen
   import trigger_wheel_pkg::*;
#(
   parameter int TEETH      = TEETH_DEF,
   parameter int MISSING    = MISSING_DEF,
   parameter int PW         = 24,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ena,
   input  logic [PW-1:0] period,
   input  logic [5:0]    cam_tooth,
   output logic          cap,
   output logic          cam,
   output logic [5:0]    tooth_idx,
   output logic          rev,
   output logic          sync,
   output logic          running
);
   // One extra bit so MISSING*P fits for MISSING <= 2
   localparam int TW = PW + 1;
   localparam logic [5:0]    LAST = 6'(TEETH - MISSING - 1);
   localparam logic [PW-1:0] PMIN = PW'(MIN_PERIOD);

   state_t          r_state, w_ns;
   logic [5:0]      r_idx, w_idx;
   logic [PW-1:0]   r_p, w_pn;
   logic [TW-1:0]   w_half, w_low, w_gap, w_ld_val;
   logic            r_rev, w_rev, r_cap, w_cap, r_cam, w_cam, r_sync, w_sync, r_run, w_run;
   logic            w_samp, w_ld, w_done;

   assign w_pn   = (period < PMIN) ? PMIN : period;
   // HIGH and GAP use the freshly sampled period; LOW uses the one latched at HIGH entry
   assign w_half = {1'b0, w_pn >> 1} - TW'(1);
   assign w_low  = {1'b0, r_p - (r_p >> 1)} - TW'(1);
   assign w_gap  = TW'(MISSING) * {1'b0, w_pn} - TW'(1);

   phase_timer #(.W(TW)) u_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_ld),
      .i_val  (w_ld_val),
      .o_done (w_done)
   );

   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_rev   <= 1'b0;
         r_p     <= PMIN;
         r_cap   <= 1'b0;
         r_cam   <= 1'b0;
         r_sync  <= 1'b0;
         r_run   <= 1'b0;
      end else begin
         r_state <= w_ns;
         r_idx   <= w_idx;
         r_rev   <= w_rev;
         if (w_samp)
            r_p <= w_pn;
         r_cap   <= w_cap;
         r_cam   <= w_cam;
         r_sync  <= w_sync;
         r_run   <= w_run;
      end

   always_comb begin
      w_ns     = r_state;
      w_idx    = r_idx;
      w_rev    = r_rev;
      w_ld     = 1'b0;
      w_ld_val = w_half;
      w_samp   = 1'b0;
      case (r_state)
         IDLE:
            if (ena) begin
               w_ns   = HIGH;
               w_idx  = '0;
               w_rev  = 1'b0;
               w_ld   = 1'b1;
               w_samp = 1'b1;
            end
         HIGH:
            if (w_done) begin
               w_ns     = LOW;
               w_ld     = 1'b1;
               w_ld_val = w_low;
            end
         LOW:
            if (w_done) begin
               if (!ena)
                  w_ns = IDLE;
               else if (r_idx == LAST) begin
                  w_ns     = GAP;
                  w_ld     = 1'b1;
                  w_ld_val = w_gap;
                  w_samp   = 1'b1;
               end else begin
                  w_ns   = HIGH;
                  w_idx  = r_idx + 6'd1;
                  w_ld   = 1'b1;
                  w_samp = 1'b1;
               end
            end
         default:
            if (w_done) begin
               if (!ena)
                  w_ns = IDLE;
               else begin
                  w_ns   = HIGH;
                  w_idx  = '0;
                  w_rev  = ~r_rev;
                  w_ld   = 1'b1;
                  w_samp = 1'b1;
               end
            end
      endcase
   end

   // Outputs are computed from the next state so the registers line up with the state
   always_comb begin
      w_cap  = (w_ns == HIGH);
      w_cam  = (w_ns == HIGH || w_ns == LOW) && (w_idx == cam_tooth) && !w_rev;
      w_sync = (r_state == HIGH) && (w_ns == LOW) && (r_idx == '0);
      w_run  = (w_ns != IDLE);
   end

   assign cap       = r_cap;
   assign cam       = r_cam;
   assign tooth_idx = r_idx;
   assign rev       = r_rev;
   assign sync      = r_sync;
   assign running   = r_run;
endmodule
